alu_issue: RTL

ALU_ISSUE -- requirements
Module: alu_issue

---
 rtl/alu_issue_pkg.sv | 107 ++++++++++
 rtl/alu_issue_alu.sv | 49 ++++
 rtl/alu_issue.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/alu_issue_pkg.sv
//------------------------------------------------------------------------------
// Module   : alu_issue_pkg
// Brief    : Alu op encodings, MIPS opcode/funct constants and decode helper.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

package alu_issue_pkg;

    typedef enum logic [2:0] {
        c_op_and = 3'b000,
        c_op_or  = 3'b001,
        c_op_add = 3'b010,
        c_op_nor = 3'b100,
        c_op_xor = 3'b101,
        c_op_sub = 3'b110
    } alu_op_e;

    // Second-operand source selector
    typedef enum logic [1:0] {
        c_bsel_zero = 2'b00,
        c_bsel_rt   = 2'b01,
        c_bsel_sext = 2'b10,
        c_bsel_zext = 2'b11
    } b_sel_e;

    localparam logic c_sgn_signed   = 1'b1;
    localparam logic c_sgn_unsigned = 1'b0;

    localparam logic [5:0] c_opc_rtype = 6'h00;
    localparam logic [5:0] c_opc_addi  = 6'h08;
    localparam logic [5:0] c_opc_addiu = 6'h09;
    localparam logic [5:0] c_opc_slti  = 6'h0A;
    localparam logic [5:0] c_opc_sltiu = 6'h0B;
    localparam logic [5:0] c_opc_andi  = 6'h0C;
    localparam logic [5:0] c_opc_ori   = 6'h0D;
    localparam logic [5:0] c_opc_xori  = 6'h0E;

    localparam logic [5:0] c_fn_add  = 6'h20;
    localparam logic [5:0] c_fn_addu = 6'h21;
    localparam logic [5:0] c_fn_sub  = 6'h22;
    localparam logic [5:0] c_fn_subu = 6'h23;
    localparam logic [5:0] c_fn_and  = 6'h24;
    localparam logic [5:0] c_fn_or   = 6'h25;
    localparam logic [5:0] c_fn_xor  = 6'h26;
    localparam logic [5:0] c_fn_nor  = 6'h27;
    localparam logic [5:0] c_fn_slt  = 6'h2A;
    localparam logic [5:0] c_fn_sltu = 6'h2B;

    typedef struct packed {
        alu_op_e op;
        logic    unsig;
        logic    slt;
        logic    trap_en;
        logic    illegal;
        b_sel_e  b_sel;
    } decode_t;

    function automatic decode_t mk_dec(input alu_op_e op, input logic unsig,
                                       input logic slt, input b_sel_e b_sel);
        decode_t d;
        d.op      = op;
        d.unsig   = unsig;
        d.slt     = slt;
        d.trap_en = (unsig == c_sgn_signed) && !slt &&
                    ((op == c_op_add) || (op == c_op_sub));
        d.illegal = 1'b0;
        d.b_sel   = b_sel;
        return d;
    endfunction

    function automatic decode_t decode(input logic [5:0] opcode, input logic [5:0] funct);
        decode_t d;
        d = '{op: c_op_and, unsig: c_sgn_unsigned, slt: 1'b0, trap_en: 1'b0,
              illegal: 1'b1, b_sel: c_bsel_zero};
        if (opcode == c_opc_rtype) begin
            case (funct)
                c_fn_add:  d = mk_dec(c_op_add, c_sgn_signed,   1'b0, c_bsel_rt);
                c_fn_addu: d = mk_dec(c_op_add, c_sgn_unsigned, 1'b0, c_bsel_rt);
                c_fn_sub:  d = mk_dec(c_op_sub, c_sgn_signed,   1'b0, c_bsel_rt);
                c_fn_subu: d = mk_dec(c_op_sub, c_sgn_unsigned, 1'b0, c_bsel_rt);
                c_fn_and:  d = mk_dec(c_op_and, c_sgn_unsigned, 1'b0, c_bsel_rt);
                c_fn_or:   d = mk_dec(c_op_or,  c_sgn_unsigned, 1'b0, c_bsel_rt);
                c_fn_xor:  d = mk_dec(c_op_xor, c_sgn_unsigned, 1'b0, c_bsel_rt);
                c_fn_nor:  d = mk_dec(c_op_nor, c_sgn_unsigned, 1'b0, c_bsel_rt);
                c_fn_slt:  d = mk_dec(c_op_sub, c_sgn_signed,   1'b1, c_bsel_rt);
                c_fn_sltu: d = mk_dec(c_op_sub, c_sgn_unsigned, 1'b1, c_bsel_rt);
                default:   ;
            endcase
        end else begin
            case (opcode)
                c_opc_addi:  d = mk_dec(c_op_add, c_sgn_signed,   1'b0, c_bsel_sext);
                c_opc_addiu: d = mk_dec(c_op_add, c_sgn_unsigned, 1'b0, c_bsel_sext);
                c_opc_slti:  d = mk_dec(c_op_sub, c_sgn_signed,   1'b1, c_bsel_sext);
                c_opc_sltiu: d = mk_dec(c_op_sub, c_sgn_unsigned, 1'b1, c_bsel_sext);
                c_opc_andi:  d = mk_dec(c_op_and, c_sgn_unsigned, 1'b0, c_bsel_zext);
                c_opc_ori:   d = mk_dec(c_op_or,  c_sgn_unsigned, 1'b0, c_bsel_zext);
                c_opc_xori:  d = mk_dec(c_op_xor, c_sgn_unsigned, 1'b0, c_bsel_zext);
                default:     ;
            endcase
        end
        return d;
    endfunction

endpackage

`default_nettype wire

// File: rtl/alu_issue_alu.sv
//------------------------------------------------------------------------------
// Module   : alu_issue_alu
// Brief    : 32-bit combinational Alu with compare and signed-overflow flags.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module alu_issue_alu
    import alu_issue_pkg::*;
(
    input  logic [31:0] i_a,
    input  logic [31:0] i_b,
    input  alu_op_e     i_op,
    input  logic        i_unsig,
    output logic [31:0] o_aluout,
    output logic        o_compout,
    output logic        o_overflow
);

    logic [31:0] w_sum;
    logic [31:0] w_diff;

    always_comb begin
        w_sum      = i_a + i_b;
        w_diff     = i_a - i_b;
        o_aluout   = '0;
        o_overflow = 1'b0;
        case (i_op)
            c_op_and: o_aluout = i_a & i_b;
            c_op_or:  o_aluout = i_a | i_b;
            c_op_nor: o_aluout = ~(i_a | i_b);
            c_op_xor: o_aluout = i_a ^ i_b;
            c_op_add: begin
                o_aluout   = w_sum;
                o_overflow = (i_a[31] == i_b[31]) && (w_sum[31] != i_a[31]);
            end
            c_op_sub: begin
                o_aluout   = w_diff;
                o_overflow = (i_a[31] != i_b[31]) && (w_diff[31] != i_a[31]);
            end
            default: ;
        endcase
        // i_unsig high selects a signed compare
        o_compout = i_unsig ? ($signed(i_a) < $signed(i_b)) : (i_a < i_b);
    end

endmodule

`default_nettype wire

// File: rtl/alu_issue.sv
//------------------------------------------------------------------------------
// Module   : alu_issue
// Brief    : Two-stage MIPS ALU issue pipeline with retired/trap counters.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module alu_issue
    import alu_issue_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [5:0]       opcode,
    input  logic [5:0]       funct,
    input  logic [31:0]      rs_val,
    input  logic [31:0]      rt_val,
    input  logic [15:0]      imm,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      result,
    output logic             ovf_trap,
    output logic             illegal,
    output logic [CNT_W-1:0] retired_cnt,
    output logic [CNT_W-1:0] trap_cnt
);

    decode_t     w_dec;
    logic [31:0] w_a;
    logic [31:0] w_b;

    always_comb begin
        w_dec = decode(opcode, funct);
        w_a   = w_dec.illegal ? 32'h0 : rs_val;
        case (w_dec.b_sel)
            c_bsel_rt:   w_b = rt_val;
            c_bsel_sext: w_b = {{16{imm[15]}}, imm};
            c_bsel_zext: w_b = {16'h0, imm};
            default:     w_b = 32'h0;
        endcase
    end

    logic        r_s1_valid;
    alu_op_e     r_s1_op;
    logic        r_s1_unsig;
    logic        r_s1_slt;
    logic        r_s1_trap_en;
    logic        r_s1_illegal;
    logic [31:0] r_s1_a;
    logic [31:0] r_s1_b;

    logic        r_s2_valid;
    logic [31:0] r_result;
    logic        r_ovf_trap;
    logic        r_illegal;
    logic [CNT_W-1:0] r_retired;
    logic [CNT_W-1:0] r_trap;

    logic        w_s2_free;
    logic        w_in_fire;
    logic        w_out_fire;
    logic [31:0] w_aluout;
    logic        w_compout;
    logic        w_overflow;

    assign w_s2_free  = !r_s2_valid || out_ready;
    assign in_ready   = !r_s1_valid || w_s2_free;
    assign w_in_fire  = in_valid && in_ready;
    assign w_out_fire = r_s2_valid && out_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_s1_valid   <= 1'b0;
            r_s1_op      <= c_op_and;
            r_s1_unsig   <= 1'b0;
            r_s1_slt     <= 1'b0;
            r_s1_trap_en <= 1'b0;
            r_s1_illegal <= 1'b0;
            r_s1_a       <= '0;
            r_s1_b       <= '0;
        end else if (in_ready) begin
            r_s1_valid <= in_valid;
            if (w_in_fire) begin
                r_s1_op      <= w_dec.op;
                r_s1_unsig   <= w_dec.unsig;
                r_s1_slt     <= w_dec.slt;
                r_s1_trap_en <= w_dec.trap_en;
                r_s1_illegal <= w_dec.illegal;
                r_s1_a       <= w_a;
                r_s1_b       <= w_b;
            end
        end
    end

    alu_issue_alu u_alu (
        .i_a        (r_s1_a),
        .i_b        (r_s1_b),
        .i_op       (r_s1_op),
        .i_unsig    (r_s1_unsig),
        .o_aluout   (w_aluout),
        .o_compout  (w_compout),
        .o_overflow (w_overflow)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_s2_valid <= 1'b0;
            r_result   <= '0;
            r_ovf_trap <= 1'b0;
            r_illegal  <= 1'b0;
        end else if (w_s2_free) begin
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_result   <= r_s1_slt ? {31'b0, w_compout} : w_aluout;
                r_ovf_trap <= w_overflow && r_s1_trap_en;
                r_illegal  <= r_s1_illegal;
            end
        end
    end

    // Counters saturate at all-ones
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_retired <= '0;
            r_trap    <= '0;
        end else if (w_out_fire) begin
            if (r_retired != {CNT_W{1'b1}})
                r_retired <= r_retired + CNT_W'(1);
            if ((r_ovf_trap || r_illegal) && (r_trap != {CNT_W{1'b1}}))
                r_trap <= r_trap + CNT_W'(1);
        end
    end

    assign out_valid   = r_s2_valid;
    assign result      = r_result;
    assign ovf_trap    = r_ovf_trap;
    assign illegal     = r_illegal;
    assign retired_cnt = r_retired;
    assign trap_cnt    = r_trap;

endmodule

`default_nettype wire
